// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath widths, major opcodes and
// the fetch FSM state encoding.
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int OPC_W = 7;

   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of {pc, data}, with a single-cycle
// flush. The head entry is presented combinationally.
module ifetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [WIDTH-1:0]             head_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [PW-1:0] LAST     = PW'(DEPTH-1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   // Storage needs no reset: count gates every read through empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch front end: issues word fetches, buffers returned
// instructions, and squashes in-flight fetches on a branch redirect.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_RUN   | fetching; every response is pushed into the buffer
//  ST_DRAIN | after a redirect; stale responses dropped until none left
module ifetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [XLEN-1:0]   imem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [XLEN-1:0]   inst_data,
   output logic [XLEN-1:0]   inst_pc,
   output logic [OPC_W-1:0]  opcode,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

   fetch_state_e      state;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   rsp_pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     discard_cnt;
   logic [CW-1:0]     rsp_left;
   logic [CW-1:0]     buf_count;
   logic [CW:0]       in_flight;
   logic              buf_full;
   logic              buf_empty;
   logic              req_fire;
   logic              rsp_push;
   logic              pop;
   logic [2*XLEN-1:0] head;

   // Buffer occupancy is the registered count, so a slot freed by a pop this
   // cycle only becomes available for a new request next cycle.
   assign in_flight      = {1'b0, outstanding} + {1'b0, buf_count};
   assign imem_req_valid = rst_n && (state == ST_RUN) && !redirect_valid
                           && (in_flight < LIMIT);
   assign imem_addr      = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_push = imem_rsp_valid && (state == ST_RUN) && !redirect_valid;
   assign rsp_left = outstanding - CW'(imem_rsp_valid);

   assign inst_valid         = !buf_empty;
   assign {inst_pc, inst_data} = head;
   assign opcode             = inst_data[OPC_W-1:0];
   assign pop                = inst_valid && inst_ready;

   ifetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rsp_push),
      .push_data ({rsp_pc, imem_rsp_data}),
      .pop       (pop),
      .flush     (redirect_valid),
      .head_data (head),
      .full      (buf_full),
      .empty     (buf_empty),
      .count     (buf_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else if (req_fire && !imem_rsp_valid) begin
         outstanding <= outstanding + 1'b1;
      end else if (!req_fire && imem_rsp_valid) begin
         outstanding <= outstanding - 1'b1;
      end
   end

   // rsp_pc tracks the address of the next response that will be kept;
   // requests are only issued in ST_RUN, so it realigns on every redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         discard_cnt <= '0;
      end else if (redirect_valid) begin
         pc          <= align_word(redirect_pc);
         rsp_pc      <= align_word(redirect_pc);
         discard_cnt <= rsp_left;
         state       <= (rsp_left != '0) ? ST_DRAIN : ST_RUN;
      end else begin
         if (req_fire) pc <= pc + 32'd4;
         case (state)
            ST_RUN: begin
               if (rsp_push) rsp_pc <= rsp_pc + 32'd4;
            end
            ST_DRAIN: begin
               if (imem_rsp_valid) begin
                  discard_cnt <= discard_cnt - 1'b1;
                  if (discard_cnt == CW'(1)) state <= ST_RUN;
               end else if (discard_cnt == '0) begin
                  state <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a latency-configurable memory model plus one
// task per scenario, each with hand-computed expectations.
module tb_ifetch;
   import riscv_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b1;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [6:0]  opcode;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   int n_cmp = 0;
   int n_bad = 0;
   int mem_lat = 1;
   int mcyc = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic [6:0]  op;
   } dlv_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   dlv_t        got[$];
   logic [31:0] reqs[$];
   pend_t       pend_q[$];

   ifetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .opcode         (opcode),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] op_for(input logic [1:0] sel);
      case (sel)
         2'd0:    return 7'b0000011;
         2'd1:    return 7'b0100011;
         2'd2:    return 7'b0110011;
         default: return 7'b1100011;
      endcase
   endfunction

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[26:2], op_for(a[3:2])};
   endfunction

   // Memory: acceptance observed mid-cycle, response driven mem_lat cycles later.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         pend_q.delete();
         imem_rsp_valid = 1'b0;
      end else begin
         mcyc++;
         imem_rsp_valid = 1'b0;
         if (pend_q.size() > 0 && pend_q[0].due <= mcyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(pend_q[0].addr);
            void'(pend_q.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            pend_q.push_back('{imem_addr, mcyc + mem_lat});
            reqs.push_back(imem_addr);
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (rst_n && inst_valid && inst_ready) got.push_back({inst_pc, inst_data, opcode});
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      got.delete();
      reqs.delete();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
      @(negedge clk);
      got.delete();
      reqs.delete();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
      n_cmp++; if (imem_addr !== RST_PC) begin n_bad++; $display("FAIL first_req_addr: got %h want %h", imem_addr, RST_PC); end
   endtask

   task automatic test_stream();
      logic [6:0] exp_op [4];
      exp_op = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011};
      mem_lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      repeat (30) @(negedge clk);
      n_cmp++; if (got.size() < 8) begin n_bad++; $display("FAIL stream_count: got %0d want >=8", got.size()); end
      for (int i = 0; i < 8; i++) begin
         if (i < got.size()) begin
            n_cmp++; if (got[i].pc !== 32'(4*i)) begin n_bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, got[i].pc, 32'(4*i)); end
            n_cmp++; if (got[i].data !== mem_data(32'(4*i))) begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, got[i].data, mem_data(32'(4*i))); end
            n_cmp++; if (got[i].op !== exp_op[i%4]) begin n_bad++; $display("FAIL stream_op[%0d]: got %b want %b", i, got[i].op, exp_op[i%4]); end
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (i >= reqs.size() || reqs[i] !== 32'(4*i)) begin n_bad++; $display("FAIL stream_req[%0d]: size %0d want addr %h", i, reqs.size(), 32'(4*i)); end
      end
   endtask

   task automatic test_req_stall();
      mem_lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL stall_hold[%0d]: got v=%b a=%h want v=1 a=0", i, imem_req_valid, imem_addr); end
         @(negedge clk);
      end
      n_cmp++; if (reqs.size() != 0) begin n_bad++; $display("FAIL stall_no_xfer: got %0d want 0", reqs.size()); end
      imem_req_ready = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin n_bad++; $display("FAIL stall_advance: got v=%b a=%h want v=1 a=4", imem_req_valid, imem_addr); end
      n_cmp++; if (reqs.size() < 1 || reqs[0] !== 32'h0) begin n_bad++; $display("FAIL stall_first: size %0d want addr 0", reqs.size()); end
   endtask

   task automatic test_backpressure();
      mem_lat = 1; inst_ready = 1'b0; imem_req_ready = 1'b1;
      do_reset();
      repeat (10) @(negedge clk);
      #1;
      n_cmp++; if (reqs.size() != 2) begin n_bad++; $display("FAIL bp_req_count: got %0d want 2", reqs.size()); end
      n_cmp++; if (dut.u_fifo.full !== 1'b1) begin n_bad++; $display("FAIL bp_full: got %b want 1", dut.u_fifo.full); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
      @(negedge clk);
      inst_ready = 1'b1;
      repeat (10) @(negedge clk);
      n_cmp++; if (got.size() < 2 || got[0].pc !== 32'h0 || got[1].pc !== 32'h4) begin n_bad++; $display("FAIL bp_order: size %0d want pcs 0,4", got.size()); end
      n_cmp++; if (reqs.size() < 3 || reqs[2] !== 32'h8) begin n_bad++; $display("FAIL bp_resume: size %0d want third addr 8", reqs.size()); end
   endtask

   task automatic test_flush_full();
      mem_lat = 1; inst_ready = 1'b0; imem_req_ready = 1'b1;
      do_reset();
      repeat (10) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL flush_req_gate: got %b want 0", imem_req_valid); end
      @(negedge clk);
      redirect_valid = 1'b0;
      got.delete();
      #1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty: got %b want 0", inst_valid); end
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin n_bad++; $display("FAIL flush_target: got v=%b a=%h want v=1 a=40", imem_req_valid, imem_addr); end
      inst_ready = 1'b1;
      repeat (8) @(negedge clk);
      n_cmp++; if (got.size() < 1 || got[0].pc !== 32'h40 || got[0].data !== mem_data(32'h40)) begin n_bad++; $display("FAIL flush_deliver: size %0d want pc 40", got.size()); end
   endtask

   task automatic test_redirect_two();
      mem_lat = 3; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL r2_limit: got %b want 0", imem_req_valid); end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
      reqs.delete(); got.delete();
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      n_cmp++; if (dut.state !== ST_DRAIN || dut.discard_cnt !== 2'd2) begin n_bad++; $display("FAIL r2_drain: got st=%0d cnt=%0d want st=1 cnt=2", dut.state, dut.discard_cnt); end
      n_cmp++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL r2_hold: got v=%b a=%h want v=0 a=100", imem_req_valid, imem_addr); end
      repeat (14) @(negedge clk);
      n_cmp++; if (reqs.size() < 2 || reqs[0] !== 32'h100 || reqs[1] !== 32'h104) begin n_bad++; $display("FAIL r2_reqs: size %0d want 100,104", reqs.size()); end
      n_cmp++; if (got.size() < 1 || got[0].pc !== 32'h100 || got[0].data !== mem_data(32'h100)) begin n_bad++; $display("FAIL r2_first: size %0d want pc 100 data %h", got.size(), mem_data(32'h100)); end
   endtask

   task automatic test_redirect_rsp();
      mem_lat = 2; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      reqs.delete(); got.delete();
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      n_cmp++; if (dut.discard_cnt !== 2'd1 || dut.state !== ST_DRAIN) begin n_bad++; $display("FAIL rr_discard: got cnt=%0d st=%0d want cnt=1 st=1", dut.discard_cnt, dut.state); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rr_dropped: got inst_valid %b want 0", inst_valid); end
      @(negedge clk); #1;
      n_cmp++; if (dut.state !== ST_RUN || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin n_bad++; $display("FAIL rr_run: got st=%0d v=%b a=%h want st=0 v=1 a=200", dut.state, imem_req_valid, imem_addr); end
      repeat (10) @(negedge clk);
      n_cmp++; if (got.size() < 1 || got[0].pc !== 32'h200 || got[0].data !== mem_data(32'h200)) begin n_bad++; $display("FAIL rr_first: size %0d want pc 200", got.size()); end
   endtask

   task automatic test_wrap();
      mem_lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_align: got %h want fffffffc", imem_addr); end
      repeat (8) @(negedge clk);
      n_cmp++; if (reqs.size() < 3 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0 || reqs[2] !== 32'h4) begin n_bad++; $display("FAIL wrap_reqs: size %0d want fffffffc,0,4", reqs.size()); end
      n_cmp++; if (got.size() < 2 || got[0].pc !== 32'hFFFF_FFFC || got[1].pc !== 32'h0) begin n_bad++; $display("FAIL wrap_deliver: size %0d want fffffffc,0", got.size()); end
   endtask

   task automatic test_reset_midflight();
      bit found = 1'b0;
      mem_lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk); #1;
         if (imem_req_valid && inst_valid) found = 1'b1;
      end
      n_cmp++; if (!found) begin n_bad++; $display("FAIL mid_setup: got no cycle with both valids want one within 20"); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async: got req=%b inst=%b want 0,0", imem_req_valid, inst_valid); end
      repeat (2) @(negedge clk);
      got.delete(); reqs.delete();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin n_bad++; $display("FAIL mid_restart: got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_addr, RST_PC); end
      repeat (6) @(negedge clk);
      n_cmp++; if (got.size() < 1 || got[0].pc !== RST_PC || got[0].data !== mem_data(RST_PC)) begin n_bad++; $display("FAIL mid_deliver: size %0d want pc %h", got.size(), RST_PC); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_req_stall();
      test_backpressure();
      test_flush_full();
      test_redirect_two();
      test_redirect_rsp();
      test_wrap();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
